// File: rtl/writeback_unit.sv
// Writeback stage: tracks registers with outstanding writes and merges the ALU
// result path with a FIFO-buffered memory/atomic result path onto two write ports.
module writeback_unit #(
  parameter int MEM_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_pending,
  output logic        rs2_pending,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        awb_we,
  output logic [4:0]  awb_rd,
  output logic [31:0] awb_data
);

  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(MEM_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_mem [MEM_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending, pending_next;

  logic      alu_write, mem_accept, fifo_empty;
  logic      head_valid, collide, pop, push, pop_stored;
  wb_entry_t head;

  assign issue_ready = ~pending[issue_rd];
  assign rs1_pending = pending[rs1];
  assign rs2_pending = pending[rs2];
  assign mem_ready   = (count < CNT_W'(MEM_DEPTH));

  assign alu_write  = alu_valid && (alu_rd != 5'd0);
  assign mem_accept = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign fifo_empty = (count == '0);

  // An empty FIFO lets an incoming result act as the head, giving one-cycle latency.
  assign head       = fifo_empty ? wb_entry_t'{rd: mem_rd, data: mem_data} : fifo_mem[rd_ptr];
  assign head_valid = fifo_empty ? mem_accept : 1'b1;
  assign collide    = alu_write && (head.rd == alu_rd);
  assign pop        = head_valid && !collide;
  assign push       = mem_accept && !(fifo_empty && pop);
  assign pop_stored = pop && !fifo_empty;

  // NOTE: result storage carries no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wb_entry_t'{rd: mem_rd, data: mem_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_stored) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_stored})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: defaulting pending_next first keeps this block free of inferred latches.
  always_comb begin
    pending_next = pending;
    if (wb_we)  pending_next[wb_rd]  = 1'b0;
    if (awb_we) pending_next[awb_rd] = 1'b0;
    // A fresh issue outranks a clear of the same register on this edge.
    if (issue_valid && issue_ready && (issue_rd != 5'd0)) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      awb_we   <= 1'b0;
      awb_rd   <= '0;
      awb_data <= '0;
    end else begin
      wb_we  <= alu_write;
      awb_we <= pop;
      if (alu_write) begin
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end
      if (pop) begin
        awb_rd   <= head.rd;
        awb_data <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_writeback_unit;

  localparam int MEM_DEPTH = 4;

  logic        clk, reset;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_pending, rs2_pending;
  logic        alu_valid, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        wb_we, awb_we;
  logic [4:0]  wb_rd, awb_rd;
  logic [31:0] wb_data, awb_data;

  writeback_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .awb_we(awb_we), .awb_rd(awb_rd), .awb_data(awb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: outstanding registers as a bitmap, memory results as an ordered queue.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_wb_we, m_awb_we;
  logic [4:0]  m_wb_rd, m_awb_rd;
  logic [31:0] m_wb_data, m_awb_data;

  always @(posedge clk or negedge reset) begin : model
    logic alu_w, rdy, issue_ok;
    ent_t e;
    if (!reset) begin
      m_q.delete();
      m_pend = '0;
      m_wb_we = 1'b0; m_wb_rd = '0; m_wb_data = '0;
      m_awb_we = 1'b0; m_awb_rd = '0; m_awb_data = '0;
    end else begin
      alu_w    = alu_valid && (alu_rd != 5'd0);
      rdy      = (m_q.size() < MEM_DEPTH);
      issue_ok = issue_valid && (issue_rd != 5'd0) && !m_pend[issue_rd];
      if (m_wb_we)  m_pend[m_wb_rd]  = 1'b0;
      if (m_awb_we) m_pend[m_awb_rd] = 1'b0;
      if (issue_ok) m_pend[issue_rd] = 1'b1;
      if (mem_valid && rdy && (mem_rd != 5'd0)) m_q.push_back('{rd: mem_rd, data: mem_data});
      m_awb_we = 1'b0;
      if (m_q.size() > 0 && !(alu_w && m_q[0].rd == alu_rd)) begin
        e = m_q.pop_front();
        m_awb_we = 1'b1; m_awb_rd = e.rd; m_awb_data = e.data;
      end
      m_wb_we = alu_w;
      if (alu_w) begin m_wb_rd = alu_rd; m_wb_data = alu_data; end
    end
  end

  logic [4:0] awb_log[$];

  always @(negedge clk) begin
    if (reset) begin
      check("m_wb_we",    32'(wb_we),    32'(m_wb_we));
      check("m_wb_rd",    32'(wb_rd),    32'(m_wb_rd));
      check("m_wb_data",  wb_data,       m_wb_data);
      check("m_awb_we",   32'(awb_we),   32'(m_awb_we));
      check("m_awb_rd",   32'(awb_rd),   32'(m_awb_rd));
      check("m_awb_data", awb_data,      m_awb_data);
      check("m_mem_ready",   32'(mem_ready),   32'(m_q.size() < MEM_DEPTH));
      check("m_issue_ready", 32'(issue_ready), 32'(!m_pend[issue_rd]));
      check("m_rs1_pending", 32'(rs1_pending), 32'(m_pend[rs1]));
      check("m_rs2_pending", 32'(rs2_pending), 32'(m_pend[rs2]));
      check("m_dual_rd", 32'(wb_we && awb_we && (wb_rd == awb_rd)), 32'd0);
      if (awb_we) awb_log.push_back(awb_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    issue_rd = '0; alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
  endtask

  initial begin
    int idx;
    logic acc;
    reset = 1'b0;
    rs1 = '0; rs2 = '0;
    idle();
    repeat (2) step();
    check("rst_wb_we",    32'(wb_we),  32'd0);
    check("rst_wb_rd",    32'(wb_rd),  32'd0);
    check("rst_wb_data",  wb_data,     32'd0);
    check("rst_awb_we",   32'(awb_we), 32'd0);
    check("rst_awb_rd",   32'(awb_rd), 32'd0);
    check("rst_awb_data", awb_data,    32'd0);
    #3 reset = 1'b1;
    rs1 = 5'd5; issue_rd = 5'd5;
    #1;
    check("rel_mem_ready",   32'(mem_ready),   32'd1);
    check("rel_issue_ready", 32'(issue_ready), 32'd1);
    check("rel_rs1_pending", 32'(rs1_pending), 32'd0);
    step();

    // Issue rd=5, ALU result two cycles later, concurrent issue of rd=6 on the write cycle.
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 check("q31_issue_ready", 32'(issue_ready), 32'd1);
    step();
    idle();
    #1 check("q31_pend_c2", 32'(rs1_pending), 32'd1);
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1 check("q31_pend_c3", 32'(rs1_pending), 32'd1);
    step();
    idle(); issue_valid = 1'b1; issue_rd = 5'd6; rs2 = 5'd6;
    #1;
    check("q31_wb_we",   32'(wb_we), 32'd1);
    check("q31_wb_rd",   32'(wb_rd), 32'd5);
    check("q31_wb_data", wb_data,    32'h1234);
    check("q31_pend_c4", 32'(rs1_pending), 32'd1);
    step();
    idle();
    #1;
    check("q31_pend_c5",  32'(rs1_pending), 32'd0);
    check("q26_set_rd6",  32'(rs2_pending), 32'd1);
    check("q24_wb_we",    32'(wb_we), 32'd0);
    check("q24_wb_hold",  32'(wb_rd), 32'd5);

    // A memory result into an empty FIFO reaches awb_* the next cycle.
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    step();
    idle();
    #1;
    check("q22_awb_we",   32'(awb_we), 32'd1);
    check("q22_awb_rd",   32'(awb_rd), 32'd6);
    check("q22_awb_data", awb_data,    32'h66);
    step();
    #1 check("q25_rd6_clear", 32'(rs2_pending), 32'd0);

    // Re-issue of a pending register stalls until the cycle after its write.
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    #1 check("q32_blocked_a", 32'(issue_ready), 32'd0);
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1 check("q32_blocked_b", 32'(issue_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    #1;
    check("q32_wb_rd7",    32'(wb_we), 32'd1);
    check("q32_blocked_c", 32'(issue_ready), 32'd0);
    step();
    #1 check("q32_ready", 32'(issue_ready), 32'd1);
    step();
    idle(); alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    step();
    idle();
    repeat (2) step();

    // Five back-to-back memory results with free drain: never back-pressured.
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'hA0 + 32'(i);
      #1 check("q33_ready_drain", 32'(mem_ready), 32'd1);
      if (i > 0) check("q33_awb_order", 32'(awb_rd), 32'(10 + i - 1));
      step();
    end
    idle();
    #1 check("q33_awb_last", 32'(awb_rd), 32'd14);
    repeat (2) step();

    // ALU keeps colliding with the head: FIFO fills, then drains in order.
    awb_log.delete();
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      mem_valid = 1'b1; mem_rd = 5'(16 + idx); mem_data = 32'hC000 + 32'(idx);
      alu_valid = (cyc < 6); alu_rd = 5'd16; alu_data = 32'hBEEF;
      #1;
      if (cyc < 4)       check("q33_ready_fill", 32'(mem_ready), 32'd1);
      else if (cyc <= 6) check("q33_ready_full", 32'(mem_ready), 32'd0);
      acc = mem_ready;
      step();
      if (acc) idx++;
    end
    check("q33_all_sent", 32'(idx), 32'd5);
    idle();
    repeat (6) step();
    check("q33_log_size", 32'(awb_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < awb_log.size(); i++)
      check("q33_log_order", 32'(awb_log[i]), 32'(16 + i));

    // ALU and FIFO head target the same register in the same cycle.
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h900D;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA1;
    step();
    idle();
    #1;
    check("q34_wb_we",  32'(wb_we),  32'd1);
    check("q34_wb_rd",  32'(wb_rd),  32'd9);
    check("q34_awb_off", 32'(awb_we), 32'd0);
    step();
    #1;
    check("q34_awb_we",   32'(awb_we), 32'd1);
    check("q34_awb_rd",   32'(awb_rd), 32'd9);
    check("q34_awb_data", awb_data,    32'h900D);
    check("q34_wb_off",   32'(wb_we),  32'd0);
    step();

    // Results to x0 are discarded on both paths.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBAD0;
    step();
    idle();
    #1;
    check("q35_wb_we",     32'(wb_we),     32'd0);
    check("q35_awb_we",    32'(awb_we),    32'd0);
    check("q35_mem_ready", 32'(mem_ready), 32'd1);
    step();
    #1 check("q35_awb_late", 32'(awb_we), 32'd0);

    // Async reset with three buffered entries and registers 3,4 pending.
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    idle(); rs1 = 5'd3; rs2 = 5'd4;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(21 + k); mem_data = 32'hD0 + 32'(k);
      alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h2121;
      step();
    end
    idle();
    #1;
    check("q36_pre_wb_we", 32'(wb_we),       32'd1);
    check("q36_pre_rs1",   32'(rs1_pending), 32'd1);
    check("q36_pre_rs2",   32'(rs2_pending), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("q36_wb_we",    32'(wb_we),       32'd0);
    check("q36_wb_rd",    32'(wb_rd),       32'd0);
    check("q36_wb_data",  wb_data,          32'd0);
    check("q36_awb_we",   32'(awb_we),      32'd0);
    check("q36_awb_rd",   32'(awb_rd),      32'd0);
    check("q36_awb_data", awb_data,         32'd0);
    check("q36_rs1",      32'(rs1_pending), 32'd0);
    check("q36_rs2",      32'(rs2_pending), 32'd0);
    repeat (2) step();
    #2 reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("q36_no_awb",   32'(awb_we),      32'd0);
      check("q36_no_wb",    32'(wb_we),       32'd0);
      check("q36_rs1_post", 32'(rs1_pending), 32'd0);
      check("q36_rs2_post", 32'(rs2_pending), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
